fetch_unit: RTL

Instruction fetch stage ahead of the control decoder. It holds the program counter and drives a synchronous instruction ROM with one cycle of read latency. It registers each 9-bit machine word with its PC and a valid flag, and owns the `modeQ` flip-flop that selects reg-reg or reg-immediate decoding. It handles run start, stall, absolute and relative branch redirect with squash, and halt.

---
 rtl/fetch_pkg.sv | 11 +
 rtl/fetch_if.sv | 14 +
 rtl/branch_target_calc.sv | 19 +
 rtl/fetch_unit.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction fetch stage.
package fetch_pkg;
    localparam int FETCH_PC_W    = 10;
    localparam int FETCH_INSTR_W = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// Instruction ROM bus between the fetch stage (master) and a 1-cycle synchronous ROM (slave).
interface fetch_if
    import fetch_pkg::*;
#(
    parameter int PC_W    = FETCH_PC_W,
    parameter int INSTR_W = FETCH_INSTR_W
) ();
    logic               imem_en;
    logic [PC_W-1:0]    imem_addr;
    logic [INSTR_W-1:0] imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/branch_target_calc.sv
// Branch target select. FETCH_BRANCH_REL_EN builds the pc-relative adder;
// without it every branch is absolute to branch_tgt.
module branch_target_calc #(
    parameter int PC_W = 10
) (
    input  logic            branch_rel,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] branch_tgt,
    output logic [PC_W-1:0] target
);
`ifdef FETCH_BRANCH_REL_EN
    // A same-width add is the sign-extended offset add, wrapping modulo 2^PC_W.
    assign target = branch_rel ? pc + branch_tgt : branch_tgt;
`else
    logic unused_rel;
    assign unused_rel = ^{branch_rel, pc};
    assign target     = branch_tgt;
`endif
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, ROM read pipeline, branch squash, halt and decode mode flop.
// Optional relative branching is enabled with FETCH_BRANCH_REL_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W       = FETCH_PC_W,
    parameter int              INSTR_W    = FETCH_INSTR_W,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_en,
    input  logic               branch_rel,
    input  logic [PC_W-1:0]    branch_tgt,
    input  logic               setMode,
    input  logic               halt_req,
    fetch_if.master            imem,
    output logic [INSTR_W-1:0] mach_code,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               modeQ,
    output logic               done
);
    fetch_state_t       state_q, state_d;
    logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
    logic               v1_q, v1_d;
    logic [PC_W-1:0]    pc1_q, pc1_d;
    logic [INSTR_W-1:0] mach_code_q, mach_code_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               instr_valid_q, instr_valid_d;
    logic               mode_q, mode_d;
    logic [PC_W-1:0]    target;
    logic               fire;

    branch_target_calc #(.PC_W(PC_W)) u_tgt (
        .branch_rel (branch_rel),
        .pc         (pc_q),
        .branch_tgt (branch_tgt),
        .target     (target)
    );

    // Only a live, unstalled instruction may act on branch/setMode/halt.
    assign fire = instr_valid_q & ~stall;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        v1_d          = v1_q;
        pc1_d         = pc1_q;
        mach_code_d   = mach_code_q;
        pc_d          = pc_q;
        instr_valid_d = instr_valid_q;
        mode_d        = mode_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d       = RUN;
                    fetch_pc_d    = START_ADDR;
                    mode_d        = 1'b0;
                    v1_d          = 1'b0;
                    instr_valid_d = 1'b0;
                end
            end
            RUN: begin
                if (!stall) begin
                    v1_d          = 1'b1;
                    pc1_d         = fetch_pc_q;
                    fetch_pc_d    = fetch_pc_q + PC_W'(1);
                    mach_code_d   = imem.imem_rdata;
                    pc_d          = pc1_q;
                    instr_valid_d = v1_q;
                    if (fire && setMode) mode_d = ~mode_q;
                    // Halt wins over branch; the halting instruction stays on pc/mach_code.
                    if (fire && halt_req) begin
                        state_d       = DONE;
                        v1_d          = 1'b0;
                        instr_valid_d = 1'b0;
                        mach_code_d   = mach_code_q;
                        pc_d          = pc_q;
                    end else if (fire && branch_en) begin
                        fetch_pc_d    = target;
                        v1_d          = 1'b0;
                        instr_valid_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            fetch_pc_q    <= START_ADDR;
            v1_q          <= 1'b0;
            pc1_q         <= '0;
            mach_code_q   <= '0;
            pc_q          <= '0;
            instr_valid_q <= 1'b0;
            mode_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            v1_q          <= v1_d;
            pc1_q         <= pc1_d;
            mach_code_q   <= mach_code_d;
            pc_q          <= pc_d;
            instr_valid_q <= instr_valid_d;
            mode_q        <= mode_d;
        end
    end

    assign imem.imem_en   = (state_q == RUN) & ~stall;
    assign imem.imem_addr = fetch_pc_q;
    assign mach_code      = mach_code_q;
    assign instr_valid    = instr_valid_q;
    assign pc             = pc_q;
    assign modeQ          = mode_q;
    assign done           = (state_q == DONE);
endmodule
